// File: rtl/bias_relu_quant.sv
// bias_relu_quant
//   Post-accumulation stage for the 1D convolution. Each column element gets
//   the bias of the filter currently being produced, then ReLU, then an
//   arithmetic right shift by SHIFT with saturation to 0..127. The result
//   leaves over a valid/ready/last stream through a two-register pipeline.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   data_i/valid_i/last_i   input beat (COLUMN_LEN signed BW_I-bit elements)
//   ready_o                 input beat accepted when valid_i & ready_o
//   bias_we_i/addr/data     bias register file write port
//   data_o/valid_o/last_o   output beat (COLUMN_LEN signed 8-bit elements)
//   ready_i                 downstream ready
//
// The bias is assumed no wider than the input element, so the BW_I+1 bit
// stage-1 sum cannot overflow.
module bias_relu_quant #(
   parameter int COLUMN_LEN  = 1,
   parameter int FRAME_LEN   = 50,
   parameter int NUM_FILTERS = 8,
   parameter int BW_I        = 18,
   parameter int BIAS_BW     = 16,
   parameter int SHIFT       = 8,
   localparam int AW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
   localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [COLUMN_LEN*BW_I-1:0] data_i,
   input  logic                       valid_i,
   input  logic                       last_i,
   output logic                       ready_o,
   input  logic                       bias_we_i,
   input  logic [AW-1:0]              bias_addr_i,
   input  logic [BIAS_BW-1:0]         bias_data_i,
   output logic [COLUMN_LEN*8-1:0]    data_o,
   output logic                       valid_o,
   output logic                       last_o,
   input  logic                       ready_i
);

   localparam int S_W = BW_I + 1;

   function automatic logic signed [S_W-1:0] ext_data(input logic [BW_I-1:0] e);
      return {e[BW_I-1], e};
   endfunction

   function automatic logic signed [S_W-1:0] ext_bias(input logic [BIAS_BW-1:0] b);
      return {{(S_W-BIAS_BW){b[BIAS_BW-1]}}, b};
   endfunction

   // ReLU, then shift and clamp to the positive int8 range.
   function automatic logic [7:0] quant(input logic signed [S_W-1:0] s);
      logic [S_W-1:0] r;
      r = $unsigned(s >>> SHIFT);
      if (s[S_W-1])
         return 8'd0;
      else if (r > S_W'(127))
         return 8'd127;
      else
         return r[7:0];
   endfunction

   logic signed [BIAS_BW-1:0] bias [NUM_FILTERS];
   logic [PW-1:0]             pos_cnt;
   logic [AW-1:0]             filt_cnt;
   logic [BIAS_BW-1:0]        bias_sel;

   logic signed [S_W-1:0]     data_p1 [COLUMN_LEN];
   logic                      vld_p1;
   logic                      last_p1;
   logic [COLUMN_LEN*8-1:0]   data_p2;
   logic                      vld_p2;
   logic                      last_p2;

   logic load_p1;
   logic load_p2;
   logic accept;

   assign load_p2  = !vld_p2 || ready_i;
   assign load_p1  = !vld_p1 || load_p2;
   assign ready_o  = load_p1;
   assign accept   = valid_i && load_p1;
   // Combinational read: a write at this edge is seen only by later beats.
   assign bias_sel = bias[filt_cnt];

   assign data_o  = data_p2;
   assign valid_o = vld_p2;
   assign last_o  = last_p2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_FILTERS; i++) bias[i] <= '0;
      end else if (bias_we_i && ({1'b0, bias_addr_i} < (AW+1)'(NUM_FILTERS))) begin
         bias[bias_addr_i] <= bias_data_i;
      end
   end

   // last_i resynchronises both counters so short frames cannot skew the
   // filter index for the rest of the frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pos_cnt  <= '0;
         filt_cnt <= '0;
      end else if (accept) begin
         if (last_i) begin
            pos_cnt  <= '0;
            filt_cnt <= '0;
         end else if (pos_cnt == PW'(FRAME_LEN-1)) begin
            pos_cnt  <= '0;
            filt_cnt <= (filt_cnt == AW'(NUM_FILTERS-1)) ? '0 : filt_cnt + 1'b1;
         end else begin
            pos_cnt  <= pos_cnt + 1'b1;
         end
      end
   end

   // ---- stage 1: bias add ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (load_p1) begin
         vld_p1  <= valid_i;
         last_p1 <= valid_i && last_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_p1) begin
         for (int k = 0; k < COLUMN_LEN; k++)
            data_p1[k] <= ext_data(data_i[k*BW_I +: BW_I]) + ext_bias(bias_sel);
      end
   end

   // ---- stage 2: ReLU + requantize ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p2  <= 1'b0;
         last_p2 <= 1'b0;
         data_p2 <= '0;
      end else if (load_p2) begin
         vld_p2  <= vld_p1;
         last_p2 <= vld_p1 && last_p1;
         for (int k = 0; k < COLUMN_LEN; k++)
            data_p2[k*8 +: 8] <= quant(data_p1[k]);
      end
   end

endmodule

// File: tb/tb_bias_relu_quant.sv
module tb_bias_relu_quant;

   localparam int COLUMN_LEN  = 2;
   localparam int FRAME_LEN   = 4;
   localparam int NUM_FILTERS = 3;
   localparam int BW_I        = 18;
   localparam int BIAS_BW     = 16;
   localparam int SHIFT       = 8;
   localparam int AW          = 2;

   logic                       clk_i = 1'b0;
   logic                       rst_i;
   logic [COLUMN_LEN*BW_I-1:0] data_i;
   logic                       valid_i;
   logic                       last_i;
   logic                       ready_o;
   logic                       bias_we_i;
   logic [AW-1:0]              bias_addr_i;
   logic [BIAS_BW-1:0]         bias_data_i;
   logic [COLUMN_LEN*8-1:0]    data_o;
   logic                       valid_o;
   logic                       last_o;
   logic                       ready_i;

   bias_relu_quant #(
      .COLUMN_LEN(COLUMN_LEN), .FRAME_LEN(FRAME_LEN), .NUM_FILTERS(NUM_FILTERS),
      .BW_I(BW_I), .BIAS_BW(BIAS_BW), .SHIFT(SHIFT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
      .last_i(last_i), .ready_o(ready_o), .bias_we_i(bias_we_i),
      .bias_addr_i(bias_addr_i), .bias_data_i(bias_data_i), .data_o(data_o),
      .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] data;
      logic        last;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;
   bit   lat_mode = 1'b0;
   int   rdy_mode = 0;   // 0: ready, 1: random, 2: held low

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Downstream ready generator.
   initial begin
      ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         case (rdy_mode)
            1:       ready_i = 1'($urandom_range(0, 1));
            2:       ready_i = 1'b0;
            default: ready_i = 1'b1;
         endcase
      end
   end

   // Monitor: sampled on the falling edge, a transfer occurs at the next rise.
   always @(negedge clk_i) begin
      if (mon_en && !rst_i) begin
         if (valid_o) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               chk("data_o", int'(data_o), int'(q[0].data));
               chk("last_o", int'(last_o), int'(q[0].last));
               if (ready_i) begin
                  if (q[0].lat) chk("latency", cyc - q[0].cyc, 2);
                  void'(q.pop_front());
               end
            end
         end else begin
            chk("last_without_valid", int'(last_o), 0);
         end
      end
   end

   // Drive one beat; called right after a rising edge. The expected result
   // is queued when the handshake is seen.
   task automatic send(input int d0, input int d1, input bit lst,
                       input int e0, input int e1, input bit push);
      int   n = 0;
      exp_t e;
      data_i  = {d1[17:0], d0[17:0]};
      valid_i = 1'b1;
      last_i  = lst;
      @(negedge clk_i);
      while (!ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) begin
         chk("input_accept_timeout", 0, 1);
      end else if (push) begin
         e.data = {e1[7:0], e0[7:0]};
         e.last = lst;
         e.cyc  = cyc;
         e.lat  = lat_mode;
         q.push_back(e);
      end
      @(posedge clk_i);
      #1;
      valid_i   = 1'b0;
      last_i    = 1'b0;
      bias_we_i = 1'b0;
   endtask

   task automatic wr_bias(input int addr, input int val);
      bias_we_i   = 1'b1;
      bias_addr_i = addr[AW-1:0];
      bias_data_i = val[15:0];
      @(posedge clk_i);
      #1;
      bias_we_i   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk_i);
         n++;
      end
      chk("drain_queue_empty", q.size(), 0);
      @(posedge clk_i);
      #1;
   endtask

   int e0_tab [3][4] = '{'{1, 2, 3, 4}, '{2, 3, 4, 5}, '{0, 0, 1, 2}};
   int e1_tab [3]    = '{5, 6, 3};

   initial begin
      rst_i = 1'b1; data_i = '0; valid_i = 1'b0; last_i = 1'b0;
      bias_we_i = 1'b0; bias_addr_i = '0; bias_data_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("reset_valid_o", int'(valid_o), 0);
      chk("reset_last_o", int'(last_o), 0);
      chk("reset_data_o", int'(data_o), 0);
      chk("reset_ready_o", int'(ready_o), 1);
      mon_en = 1'b1;

      // Pass-through, ReLU and saturation with zero biases.
      lat_mode = 1'b1;
      send(512, 1280, 1'b0, 2, 5, 1'b1);
      send(-300, 40000, 1'b0, 0, 127, 1'b1);
      send(255, 256, 1'b0, 0, 1, 1'b1);
      send(0, 131071, 1'b1, 0, 127, 1'b1);
      drain();

      // Bias indexing across filters; out-of-range address ignored.
      wr_bias(0, 256);
      wr_bias(1, 512);
      wr_bias(2, -256);
      wr_bias(3, 32767);
      for (int i = 0; i < 4; i++) send(1024, 2000, 1'b0, 5, 8, 1'b1);
      for (int i = 0; i < 4; i++) send(1024, 2000, 1'b0, 6, 9, 1'b1);
      for (int i = 0; i < 4; i++) send(1024, 2000, 1'b0, 3, 6, 1'b1);
      send(1024, 2000, 1'b0, 5, 8, 1'b1);

      // Short frame: last on pos 2 of filter 0 restarts the counters.
      send(1024, 2000, 1'b0, 5, 8, 1'b1);
      send(1024, 2000, 1'b1, 5, 8, 1'b1);
      for (int i = 0; i < 4; i++) send(1024, 2000, 1'b0, 5, 8, 1'b1);
      send(1024, 2000, 1'b0, 6, 9, 1'b1);

      // Bias write in the same cycle as an accepted beat: old value used.
      bias_we_i = 1'b1; bias_addr_i = 2'd1; bias_data_i = 16'd1024;
      send(1024, 2000, 1'b0, 6, 9, 1'b1);
      send(1024, 2000, 1'b0, 8, 11, 1'b1);
      send(1024, 2000, 1'b1, 8, 11, 1'b1);
      drain();
      wr_bias(1, 512);

      // Backpressure: three frames, continuous valid, random ready.
      lat_mode = 1'b0;
      rdy_mode = 1;
      for (int i = 0; i < 36; i++)
         send(256 * (i % 4), 1024, (i % 12) == 11,
              e0_tab[(i / 4) % 3][i % 4], e1_tab[(i / 4) % 3], 1'b1);
      rdy_mode = 0;
      drain();

      // Reset with two beats in flight, mid-frame.
      send(1024, 2000, 1'b0, 5, 8, 1'b1);
      drain();
      mon_en = 1'b0;
      rdy_mode = 2;
      repeat (2) @(posedge clk_i);
      #1;
      send(1024, 2000, 1'b0, 0, 0, 1'b0);
      send(1024, 2000, 1'b0, 0, 0, 1'b0);
      chk("inflight_valid_o", int'(valid_o), 1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk("midreset_valid_o", int'(valid_o), 0);
      chk("midreset_last_o", int'(last_o), 0);
      chk("midreset_data_o", int'(data_o), 0);
      chk("midreset_ready_o", int'(ready_o), 1);
      rdy_mode = 0;
      repeat (2) @(posedge clk_i);
      #1;
      mon_en = 1'b1;
      lat_mode = 1'b1;
      // Biases are cleared, so outputs depend on the input only.
      send(512, 1280, 1'b0, 2, 5, 1'b1);
      send(-1, 51200, 1'b0, 0, 127, 1'b1);
      send(768, 0, 1'b1, 3, 0, 1'b1);
      drain();
      repeat (5) @(posedge clk_i);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bias_relu_quant.md
# bias_relu_quant

Post-accumulation stage that sits directly downstream of the 1D convolution's three-tap vector adder. It adds a per-filter bias to each column element, applies ReLU, and requantizes the result to signed 8-bit by arithmetic right shift with saturation. It then forwards the result to the next layer over a valid/ready/last stream. The per-filter bias is selected by internal position and filter counters that track the convolution's filter-major output order.

## Interface
- COLUMN_LEN, 1, vector elements per beat
- FRAME_LEN, 50, beats per filter pass
- NUM_FILTERS, 8, filters per frame; size of bias register file
- BW_I, 18, signed input element width (adder output)
- BIAS_BW, 16, signed bias width
- SHIFT, 8, requantization right-shift amount (0..BW_I)

- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- data_i  in  COLUMN_LEN*BW_I  signed elements; element k at bits [k*BW_I +: BW_I]
- valid_i  in  1  input beat valid
- last_i  in  1  final beat of frame
- ready_o  out  1  stage accepts a beat
- bias_we_i  in  1  bias write strobe
- bias_addr_i  in  $clog2(NUM_FILTERS)  filter index to write
- bias_data_i  in  BIAS_BW  signed bias value
- data_o  out  COLUMN_LEN*8  signed 8-bit elements, same packing
- valid_o  out  1  output beat valid
- last_o  out  1  last, delayed with its beat
- ready_i  in  1  downstream ready

## Operation
- Beat transfer: input on valid_i & ready_o; output on valid_o & ready_i.
- Input order is filter-major: FRAME_LEN beats for filter 0, then filter 1, and so on.
- pos_cnt counts 0..FRAME_LEN-1. On every accepted beat it increments.
  - On wrap it returns to 0 and filt_cnt increments.
  - filt_cnt wraps NUM_FILTERS-1 -> 0.
- An accepted beat with last_i=1 forces pos_cnt=0 and filt_cnt=0 regardless of their values. This resynchronizes the counters on short frames.
- Stage 1 (register): for each element, s1 = sext(data) + sext(bias[filt_cnt]), at width BW_I+1. The sum cannot overflow.
  - Stage 1 also registers last, with its own valid bit.
- Stage 2 (register): for each element:
  - r = (s1 < 0) ? 0 : s1 >>> SHIFT.
  - Result = (r > 127) ? 127 : r[7:0].
  - Outputs are therefore always in 0..127.
- Bias register file:
  - NUM_FILTERS x BIAS_BW, all entries 0 after reset.
  - A write on bias_we_i lands at the clock edge, so the new value is visible starting with beats accepted in the next cycle.
  - A write to the same index in the same cycle as a beat is accepted: that beat uses the old value.
  - Out-of-range bias_addr_i is ignored.

## Timing
- Latency: 2 cycles from input acceptance to valid_o, with no stall.
- Throughput: 1 beat/cycle when ready_i=1.
- Pipeline advance rules:
  - Stage 2 loads when !valid_o | ready_i.
  - Stage 1 loads when !s1_valid | stage-2 loads.
  - ready_o = !s1_valid | stage-2 load.
  - ready_o is combinational from ready_i and internal valid bits. It does not depend on valid_i.
- While valid_o=1 & ready_i=0:
  - data_o and last_o hold stable.
  - At most 2 beats are buffered, then ready_o falls.
  - No beat is dropped or duplicated.
- Reset (rst_i=1 at an edge):
  - valid_o=0, last_o=0, data_o=0, s1_valid=0.
  - Counters = 0; biases = 0.
  - In-flight beats are discarded, including mid-frame.
  - ready_o=1 in the cycle after reset deasserts.
- last_o is asserted only together with valid_o, on the beat that entered with last_i.

## Test plan
- Pass-through: biases 0, SHIFT=8, COLUMN_LEN=2, elements {512, 1280} -> output {2, 5} two cycles after acceptance; last_o matches last_i.
- ReLU/saturation: bias 0, input -300 -> 0; input 40000 -> 127; input 255 -> 0; input 256 -> 1.
- Bias indexing: FRAME_LEN=4, NUM_FILTERS=3, biases {256, 512, -256}, every input 1024 -> outputs 5,5,5,5, 6,6,6,6, 3,3,3,3; the 13th beat uses filter 0 again (5).
- Short frame: last_i on beat 2 of filter 0 -> the next beat uses bias[0] and counts pos from 0.
- Backpressure: random ready_i (50%) with continuous valid_i over 3 frames -> output sequence identical to the no-stall run, and data_o stable while stalled.
- Reset mid-stream: assert rst_i with 2 beats in flight -> valid_o=0 next cycle and no stale beat appears afterward; biases read back as 0 (all outputs equal ReLU/shift of input only).
